// File: rtl/grid_arbiter.sv
// Single-port occupancy grid shared by the arena clear sequencer, the game-engine
// port and the video port; at most one RAM access per clock.
module grid_arbiter #(
  parameter int unsigned GRID_SIZE     = 128,
  parameter int unsigned LOG_GRID_SIZE = 7,
  parameter int unsigned STARVE_LIMIT  = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     clear_done,
  input  logic                     eng_req,
  input  logic [1:0]               eng_op,
  input  logic [LOG_GRID_SIZE-1:0] eng_x,
  input  logic [LOG_GRID_SIZE-1:0] eng_y,
  input  logic                     eng_wdata,
  output logic                     eng_gnt,
  output logic                     eng_rvalid,
  output logic                     eng_rdata,
  input  logic                     vid_req,
  input  logic [LOG_GRID_SIZE-1:0] vid_x,
  input  logic [LOG_GRID_SIZE-1:0] vid_y,
  output logic                     vid_gnt,
  output logic                     vid_rvalid,
  output logic                     vid_rdata,
  output logic                     vid_miss
);

  localparam int unsigned AW = 2 * LOG_GRID_SIZE;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_TAS_WR = 2'd2;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_TAS   = 2'b10;

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;

  logic [1:0]    r_state;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] r_tas_addr;
  logic [SW-1:0] r_starve;
  logic          r_clear_done;
  logic          r_eng_rvalid;
  logic          r_vid_rvalid;
  logic          r_vid_miss;
  logic          r_rd_q;
  logic          r_grid [0:GRID_SIZE*GRID_SIZE-1];

  logic                     w_arb_open;
  logic                     w_eng_pri;
  logic                     w_eng_gnt;
  logic                     w_vid_gnt;
  logic                     w_clr_last;
  logic [LOG_GRID_SIZE-1:0] w_clr_x;
  logic [LOG_GRID_SIZE-1:0] w_clr_y;
  logic                     w_clr_wall;
  logic [AW-1:0]            w_eng_addr;
  logic [AW-1:0]            w_vid_addr;
  logic                     w_ram_we;
  logic                     w_ram_re;
  logic [AW-1:0]            w_ram_addr;
  logic                     w_ram_wdata;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_arb_open = (r_state == ST_IDLE) && !clear_req;
  assign w_eng_pri  = (r_starve == STARVE_MAX);
  assign w_vid_gnt  = w_arb_open && vid_req && !(eng_req && w_eng_pri);
  assign w_eng_gnt  = w_arb_open && eng_req && (!vid_req || w_eng_pri);

  assign w_clr_last = (r_clr_cnt == '1);
  assign w_clr_x    = r_clr_cnt[LOG_GRID_SIZE-1:0];
  assign w_clr_y    = r_clr_cnt[AW-1:LOG_GRID_SIZE];
  assign w_clr_wall = (w_clr_x == '0) || (w_clr_x == '1) ||
                      (w_clr_y == '0) || (w_clr_y == '1);

  assign w_eng_addr = {eng_y, eng_x};
  assign w_vid_addr = {vid_y, vid_x};

  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_ram_we    = w_rst_n;
        w_ram_addr  = r_clr_cnt;
        w_ram_wdata = w_clr_wall;
      end
      ST_TAS_WR: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = r_tas_addr;
        w_ram_wdata = 1'b1;
      end
      ST_IDLE: begin
        if (w_vid_gnt) begin
          w_ram_re   = 1'b1;
          w_ram_addr = w_vid_addr;
        end else if (w_eng_gnt) begin
          w_ram_addr = w_eng_addr;
          if (eng_op == OP_WRITE) begin
            w_ram_we    = 1'b1;
            w_ram_wdata = eng_wdata;
          end else begin
            w_ram_re = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) r_grid[w_ram_addr] <= w_ram_wdata;
    if (w_ram_re) r_rd_q <= r_grid[w_ram_addr];
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= ST_CLEAR;
      r_clr_cnt    <= '0;
      r_tas_addr   <= '0;
      r_starve     <= '0;
      r_clear_done <= 1'b0;
      r_eng_rvalid <= 1'b0;
      r_vid_rvalid <= 1'b0;
      r_vid_miss   <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + AW'(1);
          if (w_clr_last) begin
            r_state      <= ST_IDLE;
            r_clear_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end else if (w_eng_gnt && eng_op == OP_TAS) begin
            r_state    <= ST_TAS_WR;
            r_tas_addr <= w_eng_addr;
          end
        end
        ST_TAS_WR: r_state <= ST_IDLE;
        default: begin
          r_state   <= ST_CLEAR;
          r_clr_cnt <= '0;
        end
      endcase

      if (w_eng_gnt)                          r_starve <= '0;
      else if (eng_req && r_starve != STARVE_MAX) r_starve <= r_starve + SW'(1);

      r_eng_rvalid <= w_eng_gnt && (eng_op != OP_WRITE);
      r_vid_rvalid <= w_vid_gnt;
      r_vid_miss   <= vid_req && !w_vid_gnt;
    end
  end

  // Read data is gated so both data outputs sit at 0 whenever not valid.
  assign clear_busy = (r_state == ST_CLEAR);
  assign clear_done = r_clear_done;
  assign eng_gnt    = w_eng_gnt;
  assign vid_gnt    = w_vid_gnt;
  assign eng_rvalid = r_eng_rvalid;
  assign vid_rvalid = r_vid_rvalid;
  assign eng_rdata  = r_eng_rvalid & r_rd_q;
  assign vid_rdata  = r_vid_rvalid & r_rd_q;
  assign vid_miss   = r_vid_miss;

endmodule

// File: doc/grid_arbiter.md
Name: grid_arbiter

Overview:
- Owns the single-port GRID_SIZE x GRID_SIZE occupancy grid (1 bit per cell) used by the light-bike game.
- Shares that grid between three users:
  - a clear sequencer that builds the walled, empty arena;
  - the game-engine port, which marks trails and checks collisions;
  - the video port, which fetches the pixel to display.
- Performs at most one RAM access per clock.
- Sits between the game state machine and the VGA pixel logic, and replaces the flip-flop grid array.

Parameters:
- GRID_SIZE, 128, cells per side (power of two, minimum 4).
- LOG_GRID_SIZE, 7, log2(GRID_SIZE); width of the x and y coordinates.
- STARVE_LIMIT, 15, number of consecutive denied engine cycles after which the engine takes priority over video.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; assertion is immediate, release is synchronised to clk.
- clear_req  in  1  one-cycle pulse that starts an arena clear.
- clear_busy  out  1  high while the clear sequencer owns the RAM.
- clear_done  out  1  one-cycle pulse on the cycle after the last clear write.
- eng_req  in  1  engine access request.
- eng_op  in  2  00 = read, 01 = write, 10 = test-and-set, 11 = reserved (treated as read).
- eng_x, eng_y  in  LOG_GRID_SIZE each  engine cell coordinates.
- eng_wdata  in  1  write data for op 01.
- eng_gnt  out  1  engine request accepted this cycle (combinational).
- eng_rvalid  out  1  registered; high the cycle after an accepted read or test-and-set.
- eng_rdata  out  1  old cell value; meaningful only while eng_rvalid is high.
- vid_req  in  1  video fetch request.
- vid_x, vid_y  in  LOG_GRID_SIZE each  video cell coordinates.
- vid_gnt  out  1  video request accepted this cycle (combinational).
- vid_rvalid  out  1  registered; high the cycle after vid_gnt.
- vid_rdata  out  1  cell value; meaningful only while vid_rvalid is high.
- vid_miss  out  1  registered pulse: vid_req was high and vid_gnt was low on the previous cycle.

Behaviour:
- RAM addressing:
  - address = y*GRID_SIZE + x, i.e. the concatenation {y, x};
  - reads are synchronous, data appears the next cycle;
  - a write lands at the clock edge.
- Reset:
  - state = CLEAR, clear counter = 0;
  - clear_busy = 1;
  - all other outputs = 0;
  - starvation counter = 0;
  - RAM contents are undefined until the first clear completes.
- States: IDLE, CLEAR, TAS_WR.
- CLEAR:
  - writes one cell per cycle in address order 0 .. GRID_SIZE^2-1;
  - written data = 1 when x==0, x==GRID_SIZE-1, y==0 or y==GRID_SIZE-1; otherwise 0;
  - takes exactly GRID_SIZE^2 cycles;
  - after the last address: go to IDLE, drop clear_busy, pulse clear_done for one cycle;
  - eng_gnt and vid_gnt stay 0 throughout;
  - clear_req arriving during CLEAR is ignored; the clear does not restart.
- IDLE priority:
  - clear_req beats everything: enter CLEAR next cycle with no RAM access this cycle, and deny both ports.
  - Otherwise video beats engine, unless the starvation counter has reached STARVE_LIMIT, in which case the engine wins.
  - The starvation counter increments each cycle that eng_req is high and eng_gnt is low, saturates at STARVE_LIMIT, and resets to 0 on eng_gnt.
- Engine ops:
  - read: eng_rvalid/eng_rdata follow one cycle after the grant.
  - write: one cycle; no rvalid.
  - test-and-set, atomic:
    - grant cycle = read;
    - then state TAS_WR writes 1 to the same latched address;
    - eng_rvalid carries the old value in the TAS_WR cycle;
    - in TAS_WR both gnts are 0, and a pending vid_req produces vid_miss the following cycle;
    - return to IDLE.
- Read-after-write: the engine reading the cell written one cycle earlier sees the new value. Reads return current RAM contents with no bypass issue, because each write completes at its edge.
- Request rules:
  - a requester must hold req, address and op stable until it sees its gnt;
  - a dropped request has no effect;
  - the arbiter never grants a request that is low.
- Asynchronous reset mid-TAS: the TAS write is lost; the clear overwrites the cell anyway.

Test Plan:
- Reset then release, GRID_SIZE=8 -> clear_busy=1 for exactly 64 cycles, then clear_done pulses once. Video reads show (0,3)=1, (7,5)=1, (3,3)=0, (3,0)=1.
- Engine write (3,4)=1, then engine read (3,4) -> eng_rvalid=1, eng_rdata=1 one cycle after the read grant. A video read of (3,4) also returns 1.
- Test-and-set (2,2) on a cleared grid -> eng_rdata=0, TAS_WR occupies one cycle, and vid_req held during it gives vid_miss=1. A second test-and-set of (2,2) returns 1.
- vid_req and eng_req both held continuously -> video granted for 15 consecutive cycles, engine granted on the 16th, then video resumes. Counter reads 0 after the engine grant.
- clear_req in the same cycle as vid_req and eng_req -> neither granted, clear_busy=1 next cycle. A second clear_req 10 cycles in does not extend the 64-cycle clear.
- Assert reset during TAS_WR -> all outputs go to 0 immediately except clear_busy=1. After release, a full clear runs, and the cell reads back its clear value (0 for interior cell (2,2)).
